// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: ALU op selects, forwarding selects and the
// execute-to-memory register layout used by decode, execute and hazard logic.
package pipeline_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] write_data;
        logic [31:0] alu_result;
    } ex_mem_t;

    // Select code 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [31:0] fwd_select(
        input logic [1:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] wb_val,
        input logic [31:0] mem_val
    );
        logic [31:0] r;
        case (sel)
            FWD_WB:  r = wb_val;
            FWD_MEM: r = mem_val;
            default: r = reg_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU: add/sub (modulo 2^32), and, or, signed set-less-than; other codes give 0.
module alu
    import pipeline_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {31'b0, $signed(A) < $signed(B)};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == 32'h0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the
// execute-to-memory pipeline register.
module execute_cycle
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;
    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_q;

    // Forwarding from M uses the registered result, so dependent ops need no stall.
    always_comb begin
        src_a = fwd_select(ForwardA_E, RD1_E, ResultW, ex_mem_q.alu_result);
        fwd_b = fwd_select(ForwardB_E, RD2_E, ResultW, ex_mem_q.alu_result);
        src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    end

    alu u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = BranchE & zero;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = RegWriteE;
        ex_mem_d.mem_write  = MemWriteE;
        ex_mem_d.result_src = ResultSrcE;
        ex_mem_d.rd         = RD_E;
        ex_mem_d.pc_plus4   = PCPlus4E;
        ex_mem_d.write_data = fwd_b;
        ex_mem_d.alu_result = alu_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign RegWriteM   = ex_mem_q.reg_write;
    assign MemWriteM   = ex_mem_q.mem_write;
    assign ResultSrcM  = ex_mem_q.result_src;
    assign RD_M        = ex_mem_q.rd;
    assign PCPlus4M    = ex_mem_q.pc_plus4;
    assign WriteDataM  = ex_mem_q.write_data;
    assign ALU_ResultM = ex_mem_q.alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: a behavioural reference checked every negedge,
// plus directed vectors with hand-computed literal expectations.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int n_pass  = 0;
    int n_total = 0;

    execute_cycle dut (
        .clk (clk), .rst (rst),
        .RegWriteE (RegWriteE), .ALUSrcE (ALUSrcE), .MemWriteE (MemWriteE),
        .ResultSrcE (ResultSrcE), .BranchE (BranchE), .ALUControlE (ALUControlE),
        .RD1_E (RD1_E), .RD2_E (RD2_E), .Imm_Ext_E (Imm_Ext_E), .PCE (PCE),
        .PCPlus4E (PCPlus4E), .RD_E (RD_E), .ResultW (ResultW),
        .ForwardA_E (ForwardA_E), .ForwardB_E (ForwardB_E),
        .PCSrcE (PCSrcE), .PCTargetE (PCTargetE),
        .RegWriteM (RegWriteM), .MemWriteM (MemWriteM), .ResultSrcM (ResultSrcM),
        .RD_M (RD_M), .PCPlus4M (PCPlus4M), .WriteDataM (WriteDataM),
        .ALU_ResultM (ALU_ResultM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic        m_rw, m_mw, m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_pc4, m_wd, m_alu;

    function automatic logic [31:0] ref_pick(input logic [1:0] sel, input logic [31:0] r,
                                             input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned s;
        case (op)
            3'd0: begin s = longint'(a) + longint'(b); return s[31:0]; end
            3'd1: begin s = (longint'(1) << 32) + longint'(a) - longint'(b); return s[31:0]; end
            3'd2: return a & b;
            3'd3: return a | b;
            // signs differ: the negative one is smaller; otherwise unsigned order holds
            3'd5: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_a();
        return ref_pick(ForwardA_E, RD1_E, ResultW, m_alu);
    endfunction

    function automatic logic [31:0] ref_fb();
        return ref_pick(ForwardB_E, RD2_E, ResultW, m_alu);
    endfunction

    function automatic logic [31:0] ref_res();
        return ref_alu(ALUControlE, ref_a(), ALUSrcE ? Imm_Ext_E : ref_fb());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rw <= 1'b0; m_mw <= 1'b0; m_rs <= 1'b0; m_rd <= '0;
            m_pc4 <= '0; m_wd <= '0; m_alu <= '0;
        end else begin
            m_rw <= RegWriteE; m_mw <= MemWriteE; m_rs <= ResultSrcE; m_rd <= RD_E;
            m_pc4 <= PCPlus4E; m_wd <= ref_fb(); m_alu <= ref_res();
        end
    end

    always @(negedge clk) begin
        logic [63:0] tgt;
        tgt = longint'(PCE) + longint'(Imm_Ext_E);
        check("cyc_RegWriteM",  {31'b0, RegWriteM},  {31'b0, m_rw});
        check("cyc_MemWriteM",  {31'b0, MemWriteM},  {31'b0, m_mw});
        check("cyc_ResultSrcM", {31'b0, ResultSrcM}, {31'b0, m_rs});
        check("cyc_RD_M",       {27'b0, RD_M},       {27'b0, m_rd});
        check("cyc_PCPlus4M",   PCPlus4M,    m_pc4);
        check("cyc_WriteDataM", WriteDataM,  m_wd);
        check("cyc_ALU_ResultM", ALU_ResultM, m_alu);
        check("cyc_PCTargetE",  PCTargetE,   tgt[31:0]);
        check("cyc_PCSrcE",     {31'b0, PCSrcE}, {31'b0, BranchE && (ref_res() == 32'd0)});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; ALUSrcE = 1'b0;
        ALUControlE = op; RD1_E = a; RD2_E = b;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd2, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200};
        vecs[1] = '{3'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
        vecs[2] = '{3'd1, 32'd3,         32'd5,         32'hFFFF_FFFE};
        vecs[3] = '{3'd5, 32'd3,         32'd5,         32'd1};
        vecs[4] = '{3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
        vecs[5] = '{3'd4, 32'd5,         32'd3,         32'd0};
        vecs[6] = '{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        vecs[7] = '{3'd7, 32'h1234_5678, 32'h1,         32'd0};

        // reset with all inputs driven high
        rst = 1'b1;
        {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE} = '1;
        ALUControlE = '1; RD1_E = '1; RD2_E = '1; Imm_Ext_E = '1; PCE = '1;
        PCPlus4E = '1; RD_E = '1; ResultW = '1; ForwardA_E = '1; ForwardB_E = '1;
        step(); step();
        check("rst_RegWriteM",  {31'b0, RegWriteM}, 32'd0);
        check("rst_MemWriteM",  {31'b0, MemWriteM}, 32'd0);
        check("rst_RD_M",       {27'b0, RD_M},      32'd0);
        check("rst_ALU_ResultM", ALU_ResultM,       32'd0);
        check("rst_WriteDataM", WriteDataM,         32'd0);
        check("rst_PCPlus4M",   PCPlus4M,           32'd0);

        // release and first instruction: 5 + imm 3
        rst = 1'b0;
        {RegWriteE, MemWriteE, ResultSrcE, BranchE} = 4'b1000;
        RD_E = 5'd7; PCPlus4E = 32'h0000_0104;
        set_rr(3'd0, 32'd5, 32'd0); ALUSrcE = 1'b1; Imm_Ext_E = 32'd3;
        step();
        check("first_add", ALU_ResultM, 32'd8);
        check("first_rd",  {27'b0, RD_M}, 32'd7);
        check("first_pc4", PCPlus4M, 32'h0000_0104);

        // subtract-and-branch
        RegWriteE = 1'b0; BranchE = 1'b1;
        set_rr(3'd1, 32'h10, 32'h10); PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        check("beq_taken",  {31'b0, PCSrcE}, 32'd1);
        check("beq_target", PCTargetE, 32'h120);
        RD2_E = 32'h11;
        #1;
        check("beq_not_taken", {31'b0, PCSrcE}, 32'd0);
        step();
        check("beq_registered", ALU_ResultM, 32'hFFFF_FFFF);

        // forwarding: produce 9, then WB=7 on A and M on B
        BranchE = 1'b0; RegWriteE = 1'b1;
        set_rr(3'd0, 32'd4, 32'd0); ALUSrcE = 1'b1; Imm_Ext_E = 32'd5;
        step();
        check("fwd_prior", ALU_ResultM, 32'd9);
        set_rr(3'd0, 32'h55, 32'h66); ForwardA_E = 2'b01; ForwardB_E = 2'b10; ResultW = 32'd7;
        step();
        check("fwd_sum",   ALU_ResultM, 32'd16);
        check("fwd_wdata", WriteDataM,  32'd9);
        // swapped sources, and select 11 falls back to the register file
        ForwardA_E = 2'b10; ForwardB_E = 2'b11; RD2_E = 32'd100; ResultW = 32'd1;
        step();
        check("fwd_m_plus_rd2", ALU_ResultM, 32'd116);
        check("fwd11_wdata",    WriteDataM,  32'd100);

        // signed compare
        set_rr(3'd5, 32'hFFFF_FFFF, 32'd1);
        step();
        check("slt_neg_lt_pos", ALU_ResultM, 32'd1);
        set_rr(3'd5, 32'd1, 32'hFFFF_FFFF);
        step();
        check("slt_pos_lt_neg", ALU_ResultM, 32'd0);

        // wrap-around add, zero drives branch, PC target wrap
        set_rr(3'd0, 32'hFFFF_FFFF, 32'd1); BranchE = 1'b1; RegWriteE = 1'b0;
        PCE = 32'hFFFF_FFFC; Imm_Ext_E = 32'd8;
        #1;
        check("wrap_zero_branch", {31'b0, PCSrcE}, 32'd1);
        check("wrap_target",      PCTargetE, 32'd4);
        step();
        check("wrap_add", ALU_ResultM, 32'd0);
        BranchE = 1'b0;

        // remaining op table
        foreach (vecs[i]) begin
            set_rr(vecs[i].op, vecs[i].a, vecs[i].b);
            MemWriteE = i[0]; ResultSrcE = i[1]; RD_E = 5'(i + 3);
            step();
            check($sformatf("op_table_%0d", i), ALU_ResultM, vecs[i].exp);
        end

        // mid-operation reset drops writes immediately
        RegWriteE = 1'b1; MemWriteE = 1'b1; set_rr(3'd0, 32'd20, 32'd22);
        step();
        check("pre_rst_RegWriteM", {31'b0, RegWriteM}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_RegWriteM", {31'b0, RegWriteM}, 32'd0);
        check("mid_rst_MemWriteM", {31'b0, MemWriteM}, 32'd0);
        check("mid_rst_ALU",       ALU_ResultM, 32'd0);
        PCE = 32'h200; Imm_Ext_E = 32'h10;
        #1;
        check("rst_target_comb", PCTargetE, 32'h210);
        step();
        rst = 1'b0;
        set_rr(3'd1, 32'd50, 32'd8); MemWriteE = 1'b0;
        step();
        check("post_rst_capture", ALU_ResultM, 32'd42);
        check("post_rst_RegWriteM", {31'b0, RegWriteM}, 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 Reset: one clock; reset is asynchronous and active-high; port names clk and rst.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  decoded controls from the decode stage.
REQ-005 ALUControlE  in  3  ALU op select.
REQ-006 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate and PC values from the decode stage.
REQ-007 RD_E  in  5  destination register.
REQ-008 ResultW  in  32  writeback result for forwarding.
REQ-009 ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit.
REQ-010 PCSrcE  out  1  branch taken, to fetch.
REQ-011 PCTargetE  out  32  branch target, to fetch.
REQ-012 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls to the memory stage.
REQ-013 RD_M  out  5  registered destination register.
REQ-014 PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  registered values to the memory stage.

Function
REQ-015 SrcA SHALL be RD1_E for ForwardA_E=00, ResultW for 01, ALU_ResultM for 10, and RD1_E for 11.
REQ-016 Forwarded B SHALL use the same mapping with RD2_E; WriteDataE SHALL equal forwarded B.
REQ-017 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else forwarded B.
REQ-018 ALU ops: 000 add; 001 sub; 010 and; 011 or; 101 signed set-less-than (result 0 or 1); all other codes yield 0.
REQ-019 ALU add and sub SHALL be 32-bit modulo with no overflow trap; carry is discarded.
REQ-020 Zero SHALL be 1 exactly when the ALU result equals 32'h0.
REQ-021 PCTargetE SHALL be PCE + Imm_Ext_E, modulo 2^32, combinational.
REQ-022 PCSrcE SHALL be BranchE & Zero, combinational, same cycle as the inputs.
REQ-023 Execute-to-memory register: on each rising clk with rst low, the M outputs SHALL capture RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, WriteDataE and the ALU result, for a latency of 1 cycle.
REQ-024 ALU_ResultM fed back through forward select 10 SHALL be the registered value, so back-to-back dependent ops forward without a stall.
REQ-025 If ForwardA_E and ForwardB_E select different sources in the same cycle, each SHALL resolve independently.
REQ-026 A taken branch SHALL still register its E-stage values. Flushing is owned by the hazard unit, and BranchE instructions have RegWriteE=MemWriteE=0.

Reset
REQ-027 While rst=1, all M outputs SHALL be 0 asynchronously, including RegWriteM and MemWriteM, so no spurious write occurs.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight instruction; the first edge after release captures the current E inputs.
REQ-029 PCSrcE and PCTargetE SHALL remain combinational and are not affected by rst.

Structure
REQ-030 The ALU op encodings and forward-select encodings SHALL be localparams in a shared package, pipeline_pkg, used by decode, execute and the hazard unit.
REQ-031 The ALU SHALL be a separate sub-module named alu, with ports A, B, ALUControl, Result and Zero; the forwarding muxes and pipeline register stay in execute_cycle.

Verification
REQ-032 Reset: hold rst=1 with all inputs at 1s -> all M outputs read 0; release rst, apply RD1_E=5, Imm=3, ALUSrcE=1, op=000 -> ALU_ResultM=8 after 1 edge.
REQ-033 Subtract and branch: RD1_E=RD2_E=32'h10, op=001, BranchE=1, PCE=32'h100, Imm=32'h20 -> PCSrcE=1 and PCTargetE=32'h120 in the same cycle; with RD2_E=32'h11 -> PCSrcE=0.
REQ-034 Forwarding: ForwardA_E=01 with ResultW=7, and ForwardB_E=10 with prior ALU_ResultM=9, op=000, ALUSrcE=0 -> next ALU_ResultM=16 and WriteDataM=9.
REQ-035 Signed compare: op=101 with A=32'hFFFFFFFF and B=1 -> result 1; with A=1 and B=32'hFFFFFFFF -> result 0.
REQ-036 Wrap-around: A=32'hFFFFFFFF, B=1, op=000 -> result 0 and Zero=1; PCE=32'hFFFFFFFC with Imm=8 -> PCTargetE=4.
REQ-037 Mid-operation reset: assert rst between edges while RegWriteE=1 -> RegWriteM drops to 0 immediately, without waiting for a clock edge.
